// File: rtl/sap_alu.sv
// sap_alu: SAP-1 ALU stage with single-cycle ADD/SUB/AND and WIDTH-cycle shift-add MUL.
// Define ALU_FLAGS_EN to build registered carry/zero flags; otherwise both are tied low.
module sap_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             start,
    input  logic             eu,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             carry,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MUL = 1'b1;

    logic [0:0]         state;
    logic [2*WIDTH-1:0] mcand, acc, acc_next;
    logic [WIDTH-1:0]   mplier, result, res_next, alu_res;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     sum;
    logic               done_r, last, ld_op, ld;

    // SUB is a + ~b + 1, so op[0] selects both the inversion and the carry-in
    assign sum      = {1'b0, a} + {1'b0, (op[0] ? ~b : b)} + {{WIDTH{1'b0}}, op[0]};
    assign alu_res  = (op == OP_AND) ? (a & b) : sum[WIDTH-1:0];
    assign acc_next = mplier[0] ? acc + mcand : acc;
    assign last     = (state == MUL) && (cnt == CW'(WIDTH - 1));
    assign ld_op    = (state == IDLE) && start && (op != OP_MUL);
    assign ld       = ld_op || last;
    assign res_next = last ? acc_next[WIDTH-1:0] : alu_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= ld;
            if (ld)
                result <= res_next;
            if (state == IDLE) begin
                if (start && op == OP_MUL) begin
                    state  <= MUL;
                    mcand  <= {{WIDTH{1'b0}}, a};
                    mplier <= b;
                    acc    <= '0;
                    cnt    <= '0;
                end
            end else begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
                if (last)
                    state <= IDLE;
            end
        end
    end

    assign out  = eu ? result : '0;
    assign busy = (state == MUL);
    assign done = done_r;

`ifdef ALU_FLAGS_EN
    logic carry_r, zero_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_r <= 1'b0;
            zero_r  <= 1'b0;
        end else if (ld) begin
            carry_r <= last ? |acc_next[2*WIDTH-1:WIDTH] : (op != OP_AND) && sum[WIDTH];
            zero_r  <= (res_next == '0);
        end
    end

    assign carry = carry_r;
    assign zero  = zero_r;
`else
    logic unused_carry;
    assign unused_carry = sum[WIDTH];
    assign carry = 1'b0;
    assign zero  = 1'b0;
`endif
endmodule
